// File: rtl/hangman_pkg.sv
// Shared constants and types for the hangman keyboard front end.
package hangman_pkg;

  // PS/2 set-2 prefix bytes
  localparam logic [7:0] SC_EXT = 8'hE0;
  localparam logic [7:0] SC_BRK = 8'hF0;

  localparam int LETTER_W    = 5;
  localparam int NUM_LETTERS = 26;

  // Prefix-tracking state of the scan-code parser
  typedef enum logic [1:0] {
    IDLE    = 2'd0,
    EXT     = 2'd1,
    BRK     = 2'd2,
    EXT_BRK = 2'd3
  } kb_state_e;

endpackage

// File: rtl/scancode_to_letter.sv
// Combinational set-2 scan code to letter index lookup (A=0 .. Z=25).
module scancode_to_letter
  import hangman_pkg::*;
(
  input  logic [7:0]          scan_code,
  output logic                hit,
  output logic [LETTER_W-1:0] idx
);

  // Map each letter make code to its alphabet position; anything else misses
  always_comb begin
    // NOTE: every output gets a default first so no path leaves it unassigned (no latch).
    hit = 1'b1;
    idx = '0;
    unique case (scan_code)
      8'h1C: idx = 5'd0;
      8'h32: idx = 5'd1;
      8'h21: idx = 5'd2;
      8'h23: idx = 5'd3;
      8'h24: idx = 5'd4;
      8'h2B: idx = 5'd5;
      8'h34: idx = 5'd6;
      8'h33: idx = 5'd7;
      8'h43: idx = 5'd8;
      8'h3B: idx = 5'd9;
      8'h42: idx = 5'd10;
      8'h4B: idx = 5'd11;
      8'h3A: idx = 5'd12;
      8'h31: idx = 5'd13;
      8'h44: idx = 5'd14;
      8'h4D: idx = 5'd15;
      8'h15: idx = 5'd16;
      8'h2D: idx = 5'd17;
      8'h1B: idx = 5'd18;
      8'h2C: idx = 5'd19;
      8'h3C: idx = 5'd20;
      8'h2A: idx = 5'd21;
      8'h1D: idx = 5'd22;
      8'h22: idx = 5'd23;
      8'h35: idx = 5'd24;
      8'h1A: idx = 5'd25;
      default: hit = 1'b0;
    endcase
  end

endmodule

// File: rtl/guess_input.sv
// Keyboard guess front end: parses PS/2 set-2 bytes, filters repeats,
// already-guessed letters and too-early presses, and emits load/load_x.
module guess_input
  import hangman_pkg::*;
#(
  parameter int unsigned GAP_CYCLES = 4
) (
  input  logic                   clk,
  input  logic                   reset,
  input  logic                   scan_valid,
  input  logic [7:0]             scan_code,
  input  logic                   enable,
  input  logic [NUM_LETTERS-1:0] current_mask,
  output logic                   load,
  output logic [LETTER_W-1:0]    load_x,
  output logic                   dup,
  output logic                   busy
);

  localparam logic [7:0] GAP_LOAD = 8'(GAP_CYCLES - 1);

  kb_state_e             state;
  logic                  held;
  logic [7:0]            held_code;
  logic [7:0]            gap_cnt;
  logic                  hit;
  logic [LETTER_W-1:0]   idx;
  logic                  is_make;
  logic                  accept;
  logic                  emit;
  logic                  guessed;

  scancode_to_letter u_lut (
    .scan_code (scan_code),
    .hit       (hit),
    .idx       (idx)
  );

  // A fresh letter press: make code in IDLE that is not a typematic repeat.
  // Emission additionally needs the game running, no cooldown, and no dup
  // last cycle so dup never pulses on two consecutive cycles.
  assign is_make = scan_valid && (state == IDLE) &&
                   (scan_code != SC_EXT) && (scan_code != SC_BRK);
  assign accept  = is_make && hit && !(held && (scan_code == held_code));
  assign emit    = accept && enable && !busy && !dup;
  assign guessed = current_mask[idx];

  // Prefix tracking; runs regardless of enable so the byte stream never desyncs
  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      state <= IDLE;
    end else if (scan_valid) begin
      // NOTE: sequential state uses non-blocking assignments so all flops update together.
      unique case (state)
        IDLE:    state <= (scan_code == SC_EXT) ? EXT :
                          (scan_code == SC_BRK) ? BRK : IDLE;
        EXT:     state <= (scan_code == SC_BRK) ? EXT_BRK : IDLE;
        EXT_BRK: state <= IDLE;
        BRK:     state <= IDLE;
        default: state <= IDLE;
      endcase
    end
  end

  // Remember the last accepted letter until its break code arrives
  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      held      <= 1'b0;
      held_code <= 8'h00;
    end else if (accept) begin
      held      <= 1'b1;
      held_code <= scan_code;
    end else if (scan_valid && (state == BRK) && (scan_code == held_code)) begin
      held      <= 1'b0;
    end
  end

  // Registered guess/dup strobes; load_x holds the last loaded letter
  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      load   <= 1'b0;
      dup    <= 1'b0;
      load_x <= '0;
    end else begin
      load <= emit && !guessed;
      dup  <= emit && guessed;
      if (emit && !guessed) begin
        load_x <= idx;
      end
    end
  end

  // Cooldown after each load so game_process can finish its mask update
  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      gap_cnt <= 8'd0;
      busy    <= 1'b0;
    end else if (emit && !guessed) begin
      gap_cnt <= GAP_LOAD;
      busy    <= 1'b1;
    end else if (busy) begin
      if (gap_cnt == 8'd0) begin
        busy <= 1'b0;
      end else begin
        gap_cnt <= gap_cnt - 8'd1;
      end
    end
  end

endmodule

// File: tb/tb_guess_input.sv
// Scoreboard bench for guess_input: each press that should yield load or dup
// queues an expected event with its arrival time; a negedge monitor pops it.
module tb_guess_input;
  import hangman_pkg::*;

  localparam time PERIOD = 10;

  logic                   clk = 1'b0;
  logic                   reset = 1'b0;
  logic                   scan_valid = 1'b0;
  logic [7:0]             scan_code = 8'h00;
  logic                   enable = 1'b1;
  logic [NUM_LETTERS-1:0] current_mask = '0;
  logic                   load;
  logic [LETTER_W-1:0]    load_x;
  logic                   dup;
  logic                   busy;

  int vectors = 0;
  int miscompares = 0;

  typedef struct {
    bit                  is_dup;
    logic [LETTER_W-1:0] idx;
    time                 t;
  } ev_t;

  ev_t exp_q[$];
  ev_t got;

  always #(PERIOD / 2) clk = ~clk;

  guess_input #(.GAP_CYCLES(4)) dut (
    .clk          (clk),
    .reset        (reset),
    .scan_valid   (scan_valid),
    .scan_code    (scan_code),
    .enable       (enable),
    .current_mask (current_mask),
    .load         (load),
    .load_x       (load_x),
    .dup          (dup),
    .busy         (busy)
  );

  // Monitor: every load/dup must match the oldest pending expectation
  always @(negedge clk) begin
    if (reset && (load || dup)) begin
      vectors++;
      if (exp_q.size() == 0) begin
        miscompares++;
        $display("FAIL unexpected_event t=%0t got load=%0b dup=%0b load_x=%0d, required none",
                 $time, load, dup, load_x);
      end else begin
        got = exp_q.pop_front();
        if (got.is_dup) begin
          if (!(dup === 1'b1 && load === 1'b0 && $time == got.t)) begin
            miscompares++;
            $display("FAIL dup_event t=%0t got load=%0b dup=%0b, required dup=1 load=0 at t=%0t",
                     $time, load, dup, got.t);
          end
        end else begin
          if (!(load === 1'b1 && dup === 1'b0 && load_x === got.idx && $time == got.t)) begin
            miscompares++;
            $display("FAIL load_event t=%0t got load=%0b dup=%0b load_x=%0d, required load=1 load_x=%0d at t=%0t",
                     $time, load, dup, load_x, got.idx, got.t);
          end
        end
      end
    end
  end

  // Drive one byte for one cycle starting at a falling edge
  task automatic send(input logic [7:0] b);
    @(negedge clk);
    scan_valid = 1'b1;
    scan_code  = b;
  endtask

  task automatic idle(input int n);
    repeat (n) begin
      @(negedge clk);
      scan_valid = 1'b0;
    end
  endtask

  // Expected output for the byte just driven: visible one clock later
  task automatic expect_load(input logic [LETTER_W-1:0] x);
    ev_t e;
    e.is_dup = 1'b0;
    e.idx    = x;
    e.t      = $time + PERIOD;
    exp_q.push_back(e);
  endtask

  task automatic expect_dup();
    ev_t e;
    e.is_dup = 1'b1;
    e.idx    = '0;
    e.t      = $time + PERIOD;
    exp_q.push_back(e);
  endtask

  task automatic wait_not_busy(input string name);
    for (int i = 0; i < 50; i++) begin
      if (!busy) break;
      @(negedge clk);
    end
    vectors++;
    if (busy !== 1'b0) begin
      miscompares++;
      $display("FAIL %s_busy_timeout got busy=%0b, required 0 within 50 cycles", name, busy);
    end
  endtask

  task automatic check_drained(input string name);
    idle(3);
    vectors++;
    if (exp_q.size() != 0) begin
      miscompares++;
      $display("FAIL %s_missing_events got %0d pending, required 0", name, exp_q.size());
      exp_q.delete();
    end
  endtask

  task automatic test_reset();
    reset = 1'b0;
    repeat (3) @(negedge clk);
    vectors += 4;
    if (load !== 1'b0)   begin miscompares++; $display("FAIL reset_load got %0b, required 0", load); end
    if (dup !== 1'b0)    begin miscompares++; $display("FAIL reset_dup got %0b, required 0", dup); end
    if (busy !== 1'b0)   begin miscompares++; $display("FAIL reset_busy got %0b, required 0", busy); end
    if (load_x !== 5'd0) begin miscompares++; $display("FAIL reset_load_x got %0d, required 0", load_x); end
    reset = 1'b1;
    idle(2);
  endtask

  task automatic test_single_press();
    send(8'h1C); expect_load(5'd0);
    for (int i = 0; i < 5; i++) begin
      idle(1);
      vectors++;
      if (busy !== (i < 4)) begin
        miscompares++;
        $display("FAIL busy_window_cycle%0d got %0b, required %0b", i + 1, busy, (i < 4));
      end
    end
    send(8'hF0); send(8'h1C); idle(1);
    check_drained("single_press");
  endtask

  task automatic test_typematic();
    send(8'h1C); expect_load(5'd0);
    send(8'h1C); send(8'h1C);
    send(8'hF0); send(8'h1C); idle(1);
    wait_not_busy("typematic");
    send(8'h1C); expect_load(5'd0);
    send(8'hF0); send(8'h1C); idle(1);
    wait_not_busy("typematic_end");
    check_drained("typematic");
  endtask

  task automatic test_dup();
    current_mask = 26'h1 << 25;
    send(8'h1A); expect_dup();
    idle(1);
    send(8'hF0); send(8'h1A); idle(1);
    current_mask = '0;
    check_drained("dup");
  endtask

  task automatic test_extended();
    send(8'hE0); send(8'h75);
    send(8'hE0); send(8'hF0); send(8'h75);
    send(8'h2C); expect_load(5'd19);
    send(8'hF0); send(8'h2C); idle(1);
    wait_not_busy("extended");
    check_drained("extended");
  endtask

  task automatic test_cooldown();
    send(8'h24); expect_load(5'd4);
    idle(1);
    send(8'h4D);
    send(8'hF0); send(8'h4D); idle(1);
    wait_not_busy("cooldown");
    send(8'h4D); expect_load(5'd15);
    send(8'hF0); send(8'h4D); idle(1);
    wait_not_busy("cooldown_end");
    check_drained("cooldown");
  endtask

  task automatic test_back_to_back();
    // Two guessed letters back to back: dup may not pulse twice in a row
    current_mask = (26'h1 << 5) | (26'h1 << 6);
    send(8'h2B); expect_dup();
    send(8'h34);
    send(8'hF0); send(8'h2B); send(8'hF0); send(8'h34); idle(1);
    current_mask = '0;
    // Two fresh letters back to back: the second falls inside the cooldown
    send(8'h2B); expect_load(5'd5);
    send(8'h34);
    send(8'hF0); send(8'h34); idle(1);
    wait_not_busy("back_to_back");
    check_drained("back_to_back");
  endtask

  task automatic test_enable_reset();
    vectors++;
    if (load_x !== 5'd5) begin
      miscompares++;
      $display("FAIL load_x_hold got %0d, required 5", load_x);
    end
    enable = 1'b0;
    send(8'h15);
    send(8'hF0);
    @(negedge clk);
    scan_valid = 1'b0;
    #2 reset = 1'b0;
    #1;
    vectors += 4;
    if (load !== 1'b0)   begin miscompares++; $display("FAIL async_reset_load got %0b, required 0", load); end
    if (dup !== 1'b0)    begin miscompares++; $display("FAIL async_reset_dup got %0b, required 0", dup); end
    if (busy !== 1'b0)   begin miscompares++; $display("FAIL async_reset_busy got %0b, required 0", busy); end
    if (load_x !== 5'd0) begin miscompares++; $display("FAIL async_reset_load_x got %0d, required 0", load_x); end
    repeat (2) @(negedge clk);
    reset  = 1'b1;
    enable = 1'b1;
    idle(1);
    send(8'h15); expect_load(5'd16);
    idle(1);
    check_drained("enable_reset");
  endtask

  initial begin
    test_reset();
    test_single_press();
    test_typematic();
    test_dup();
    test_extended();
    test_cooldown();
    test_back_to_back();
    test_enable_reset();
    $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
    $finish;
  end

  initial begin
    #200000;
    $display("FAIL watchdog got timeout, required completion");
    $fatal(1, "watchdog expired");
  end

endmodule
